// File: rtl/div_seq_pkg.sv
// Shared definitions for the multi-cycle divider: FSM state encodings,
// handshake levels and the conditional two's-complement helper.
package div_seq_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Negation wraps modulo 2^32, so 0x80000000 maps onto itself.
  function automatic logic [DIV_WIDTH-1:0] neg_if(input logic i_neg,
                                                  input logic [DIV_WIDTH-1:0] i_val);
    return i_neg ? -i_val : i_val;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration on the 65-bit working register
// {remainder, dividend/quotient, spare}; quotient bits enter at bit 0.
module div_step
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [2*WIDTH:0]  i_work,
  input  logic [WIDTH-1:0]  i_divisor,
  output logic [2*WIDTH:0]  o_work
);

  logic             w_borrow;
  logic [WIDTH-1:0] w_diff;

  // The candidate {remainder, next dividend bit} needs 33 bits: the remainder
  // alone can reach 2^31 or more when the divisor is large.
  assign w_borrow = i_work[2*WIDTH:WIDTH] < {1'b0, i_divisor};
  assign w_diff   = i_work[2*WIDTH-1:WIDTH] - i_divisor;

  assign o_work = w_borrow ? {i_work[2*WIDTH-1:0], 1'b0}
                           : {w_diff, i_work[WIDTH-1:0], 1'b1};

endmodule

// File: rtl/div_seq.sv
// EX-stage DIV/DIVU sequencer: 32 restoring steps under a level start/ready
// handshake, result {remainder, quotient} registered for the HI/LO path.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(WIDTH - 1);
  localparam logic [DIV_CNT_W-1:0] CNT_ONE  = DIV_CNT_W'(1);

  div_state_e           r_state;
  div_state_e           w_state_nxt;
  logic [DIV_CNT_W-1:0] r_cnt;
  logic [2*WIDTH:0]     r_work;
  logic [2*WIDTH:0]     w_work_nxt;
  logic [WIDTH-1:0]     r_divisor;
  logic                 r_quo_neg;
  logic                 r_rem_neg;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_ready;
  logic [2*WIDTH-1:0]   w_result_nxt;
  logic                 w_ready_nxt;
  logic                 w_last;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_op1_mag;
  logic [WIDTH-1:0]     w_op2_mag;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  assign w_op1_mag = neg_if(signed_div_i & opdata1_i[WIDTH-1], opdata1_i);
  assign w_op2_mag = neg_if(signed_div_i & opdata2_i[WIDTH-1], opdata2_i);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_work    (r_work),
    .i_divisor (r_divisor),
    .o_work    (w_work_nxt)
  );

  // The counter reaches 32 on this cycle's increment: the final step.
  assign w_last    = (r_cnt == CNT_LAST);
  assign w_accept  = (r_state == DIV_FREE) && (w_state_nxt == DIV_ON);
  assign w_quo_fix = neg_if(r_quo_neg, w_work_nxt[WIDTH-1:0]);
  assign w_rem_fix = neg_if(r_rem_neg, w_work_nxt[2*WIDTH:WIDTH+1]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= DIV_FREE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: comb blocks assign a default first so no path leaves a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (annul_i) begin
      w_state_nxt = DIV_FREE;
    end else begin
      unique case (r_state)
        DIV_FREE:   if (start_i) w_state_nxt = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
        DIV_BYZERO: w_state_nxt = DIV_END;
        DIV_ON:     if (w_last) w_state_nxt = DIV_END;
        DIV_END:    if (!start_i) w_state_nxt = DIV_FREE;
        default:    w_state_nxt = DIV_FREE;
      endcase
    end
  end

  // Next output values; a division-by-zero entry into DIV_END keeps the zero default.
  always_comb begin
    w_ready_nxt  = DIV_RESULT_NOT_READY;
    w_result_nxt = '0;
    if (w_state_nxt == DIV_END) begin
      w_ready_nxt = DIV_RESULT_READY;
      if (r_state == DIV_ON)       w_result_nxt = {w_rem_fix, w_quo_fix};
      else if (r_state == DIV_END) w_result_nxt = r_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_result <= '0;
      r_ready  <= DIV_RESULT_NOT_READY;
    end else begin
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
      if (w_accept)                r_cnt <= '0;
      else if (r_state == DIV_ON)  r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // NOTE: operand/working registers carry no reset; they are always loaded
  // on acceptance before any step reads them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_work    <= {{WIDTH{1'b0}}, w_op1_mag, 1'b0};
      r_divisor <= w_op2_mag;
      r_quo_neg <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
      r_rem_neg <= signed_div_i & opdata1_i[WIDTH-1];
    end else if (r_state == DIV_ON) begin
      r_work    <= w_work_nxt;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule
